sw_sample_packer: RTL and testbench
===================================

SW_SAMPLE_PACKER -- requirements
Module: sw_sample_packer

Interface
REQ-001 Parameter WIDTH, default 8, is the number of y samples packed per output word; legal range is 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port y, input, 1 bit: the asynchronous output of the upstream fn_sw selector.
REQ-005 Port sample_en, input, 1 bit: when high, take one sample of the synchronized y in this cycle.
REQ-006 Port clear, input, 1 bit: synchronous flush of the partial word and the overflow flag.
REQ-007 Port out_data, output, WIDTH bits: the packed word.
REQ-008 Port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the word when out_valid and out_ready are both high.
REQ-010 Port rise_pulse, output, 1 bit: one-cycle pulse on a 0->1 transition of the synchronized y.
REQ-011 Port fall_pulse, output, 1 bit: one-cycle pulse on a 1->0 transition of the synchronized y.
REQ-012 Port overflow, output, 1 bit: sticky flag, set when a completed word was dropped.

Function
REQ-013 y passes through a 2-flop synchronizer; y_s is the second flop. A change on y is visible on y_s 2 cycles later.
REQ-014 rise_pulse and fall_pulse are registered and compare y_s with its previous value; each is high for exactly 1 cycle per edge.
REQ-015 Each sample_en cycle shifts y_s into bit 0 of the shift register, shifting left. The first sample of a word ends up in bit WIDTH-1.
REQ-016 A bit counter counts 0..WIDTH-1. The sample at count WIDTH-1 completes the word, and the counter wraps to 0 in the same cycle.
REQ-017 The output holder has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 EMPTY->FULL transition: on a completing sample, the full word (including that sample) is loaded into out_data. out_valid rises the next cycle, so latency is 1 cycle.
REQ-019 FULL->EMPTY transition: on out_valid and out_ready with no completing sample in the same cycle.
REQ-020 Simultaneous accept and completion in FULL: the new word loads, out_valid stays 1 and the state stays FULL; there is no bubble and no overflow.
REQ-021 Completion in FULL without accept: the new word is discarded, out_data is unchanged and overflow is set; the counter still wraps.
REQ-022 out_data is stable while out_valid=1 and not accepted.
REQ-023 clear resets the counter, shift register and overflow in one cycle. The holder state is unaffected. If clear and sample_en are both high, clear wins and the sample is lost.
REQ-024 overflow clears only on clear or reset.
REQ-025 out_ready is ignored while in EMPTY.

Reset
REQ-026 rst_n low asynchronously forces the following values: out_valid=0, out_data=0, overflow=0, rise_pulse=0, fall_pulse=0, counter=0, shift register=0, synchronizer flops=0, state=EMPTY.
REQ-027 Reset asserted mid-word discards the partial word; after release, packing restarts at count 0.
REQ-028 The first cycle after reset release produces no edge pulse, even if y=1.

Structure
REQ-029 Package sw_pkg holds the WIDTH default, the holder state enum {EMPTY, FULL} and the counter width function clog2(WIDTH).
REQ-030 One sub-module, sync2 (a 1-bit 2-flop synchronizer with async active-low reset), is instantiated for y.

Verification
REQ-031 WIDTH=8, out_ready=1, y held 1, sample_en high for 8 cycles after a 2-cycle sync settle -> out_data=8'hFF, out_valid for 1 cycle, overflow=0.
REQ-032 Sample sequence 1,0,1,1,0,0,1,0 with out_ready=0 -> out_data=8'hB2, out_valid stays 1; then 8 more samples -> overflow=1 and out_data is still 8'hB2.
REQ-033 FULL holding 8'hB2, 8th sample of the next word (8'h0F) coinciding with out_ready=1 -> out_data=8'h0F the next cycle, out_valid continuously 1, overflow=0.
REQ-034 y toggles 0->1->0 with 5-cycle spacing -> rise_pulse 1 cycle wide, 2 cycles after the y rise; fall_pulse likewise, 2 cycles after the y fall.
REQ-035 rst_n pulsed low after 3 of 8 samples -> all outputs 0 immediately; next 8 samples form a complete word.
REQ-036 clear asserted after 5 samples with overflow=1 -> overflow=0; a word completes only after 8 new samples.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and constants for the sample packer: default word width,
// output-holder state encoding and the counter-width helper.
package sw_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  // Smallest r with 2**r >= value, evaluated at elaboration time for counter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
// The first stage is exported so a follower can register an edge that lines up with q.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic stage1
);

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/sw_sample_packer.sv
// Synchronizes the fn_sw selector output, reports its edges and packs
// enabled samples MSB-first into WIDTH-bit words behind a one-entry holder.
module sw_sample_packer
  import sw_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y,
  input  logic             sample_en,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             overflow
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

  logic             y_s;
  logic             y_pre_s;
  logic             sample_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_n;
  // Only the samples preceding the completing one need storage.
  logic [WIDTH-2:0] shift_r;
  logic [WIDTH-2:0] shift_n;
  hold_state_t      state_r;
  hold_state_t      state_n;
  logic [WIDTH-1:0] data_n;
  logic             ovf_n;

  sync2 u_sync_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (y),
    .q      (y_s),
    .stage1 (y_pre_s)
  );

  // Edge pulses: y_pre_s is the value y_s takes next, so each pulse is high
  // in exactly the cycle where y_s differs from its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= y_pre_s & ~y_s;
      fall_pulse <= ~y_pre_s & y_s;
    end
  end

  // Sample acceptance, word assembly and counter/shift next state; clear beats sample_en.
  always_comb begin
    sample_s   = sample_en & ~clear;
    complete_s = sample_s && (cnt_r == CNT_LAST);
    word_s     = {shift_r, y_s};
    cnt_n      = cnt_r;
    shift_n    = shift_r;
    if (clear) begin
      cnt_n   = {CW{1'b0}};
      shift_n = {(WIDTH-1){1'b0}};
    end else if (sample_s) begin
      shift_n = word_s[WIDTH-2:0];
      if (complete_s) begin
        cnt_n = {CW{1'b0}};
      end else begin
        cnt_n = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_n   = cnt_r;
      shift_n = shift_r;
    end
  end

  // Bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      shift_r <= {(WIDTH-1){1'b0}};
    end else begin
      cnt_r   <= cnt_n;
      shift_r <= shift_n;
    end
  end

  // Output holder next state: load, accept, replace-on-accept or drop-with-overflow.
  always_comb begin
    state_n = state_r;
    data_n  = out_data;
    ovf_n   = overflow;
    case (state_r)
      EMPTY: begin
        if (complete_s) begin
          state_n = FULL;
          data_n  = word_s;
        end else begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (complete_s) begin
          state_n = FULL;
          if (out_ready) begin
            data_n = word_s;
          end else begin
            ovf_n = 1'b1;
          end
        end else if (out_ready) begin
          state_n = EMPTY;
        end else begin
          state_n = FULL;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
    if (clear) begin
      ovf_n = 1'b0;
    end else begin
      ovf_n = ovf_n;
    end
  end

  // Holder state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      out_data  <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r   <= state_n;
      out_data  <= data_n;
      out_valid <= (state_n == FULL);
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_sw_sample_packer.sv
// Directed and randomized bench for sw_sample_packer against a queue-based
// reference model of sync delay, word packing and the one-entry holder.
module tb_sw_sample_packer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             y;
  logic             sample_en;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  bit               dl[$];
  bit               word_q[$];
  bit               ys_m;
  bit               valid_m;
  logic [WIDTH-1:0] data_m;
  bit               ovf_m;
  bit               rise_m;
  bit               fall_m;

  always #5 clk = ~clk;

  sw_sample_packer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .sample_en  (sample_en),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dl = {1'b0};
    word_q.delete();
    ys_m = 1'b0; valid_m = 1'b0; data_m = '0;
    ovf_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0;
  endtask

  // y reaches y_s two edges after it is applied; samples see the pre-edge y_s.
  task automatic model_step();
    bit ys_old, ys_new, done;
    logic [WIDTH-1:0] w;
    w = '0;
    ys_old = ys_m;
    dl.push_back(y);
    ys_new = dl.pop_front();
    rise_m = ys_new & ~ys_old;
    fall_m = ~ys_new & ys_old;
    ys_m = ys_new;
    done = 1'b0;
    if (clear) begin
      word_q.delete();
      ovf_m = 1'b0;
    end else if (sample_en) begin
      word_q.push_back(ys_old);
      if (word_q.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = word_q[i];
        word_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (valid_m && !out_ready) ovf_m = 1'b1;
      else begin
        data_m = w;
        valid_m = 1'b1;
      end
    end else if (valid_m && out_ready) begin
      valid_m = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(valid_m));
    chk({tag, ".data"},  32'(out_data),  32'(data_m));
    chk({tag, ".ovf"},   32'(overflow),  32'(ovf_m));
    chk({tag, ".rise"},  32'(rise_pulse), 32'(rise_m));
    chk({tag, ".fall"},  32'(fall_pulse), 32'(fall_m));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic sample_bit(input bit b, input bit rdy);
    y = b; sample_en = 1'b0; out_ready = 1'b0;
    tick("settle");
    tick("settle");
    sample_en = 1'b1; out_ready = rdy;
    tick("sample");
    sample_en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) sample_bit(w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; y = 1'b0; sample_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // First cycle after release: no edge pulse even with y high.
    y = 1'b1;
    tick("post_rst");
    chk("no_pulse_first", 32'(rise_pulse), 32'd0);

    // All-ones word, consumer always ready.
    out_ready = 1'b1;
    tick("settle2");
    sample_en = 1'b1;
    repeat (WIDTH) tick("ones");
    chk("ones_data", 32'(out_data), 32'h0000_00FF);
    chk("ones_valid", 32'(out_valid), 32'd1);
    chk("ones_ovf", 32'(overflow), 32'd0);
    sample_en = 1'b0;
    tick("ones_drain");
    chk("ones_valid_1cyc", 32'(out_valid), 32'd0);

    // Word held without consumer, then a dropped word.
    send_word(8'hB2, 1'b0);
    chk("b2_data", 32'(out_data), 32'h0000_00B2);
    chk("b2_valid", 32'(out_valid), 32'd1);
    send_word(8'h55, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_data", 32'(out_data), 32'h0000_00B2);
    clear = 1'b1;
    tick("clear");
    clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_keeps_valid", 32'(out_valid), 32'd1);

    // Completion coinciding with accept: replace without bubble.
    send_word(8'h0F, 1'b1);
    chk("swap_data", 32'(out_data), 32'h0000_000F);
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_ovf", 32'(overflow), 32'd0);

    // Clear mid-word discards the partial samples.
    send_word(8'h3C, 1'b0);
    chk("ovf_again", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) sample_bit(1'(i), 1'b0);
    clear = 1'b1;
    tick("clear_mid");
    clear = 1'b0;
    chk("clear_mid_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < WIDTH - 1; i++) sample_bit(1'b1, 1'b0);
    chk("seven_no_word", 32'(overflow), 32'd0);
    sample_bit(1'b0, 1'b0);
    chk("eighth_completes", 32'(overflow), 32'd1);
    chk("eighth_data_held", 32'(out_data), 32'h0000_000F);

    // Edge pulses two cycles after each y transition, one cycle wide.
    y = 1'b0; sample_en = 1'b0;
    repeat (4) tick("idle");
    y = 1'b1;
    tick("rise0"); chk("rise_early", 32'(rise_pulse), 32'd0);
    tick("rise1"); chk("rise_at2", 32'(rise_pulse), 32'd1);
    tick("rise2"); chk("rise_width", 32'(rise_pulse), 32'd0);
    tick("hold"); tick("hold");
    y = 1'b0;
    tick("fall0"); chk("fall_early", 32'(fall_pulse), 32'd0);
    tick("fall1"); chk("fall_at2", 32'(fall_pulse), 32'd1);
    tick("fall2"); chk("fall_width", 32'(fall_pulse), 32'd0);
    tick("hold"); tick("hold");

    // Asynchronous reset mid-word.
    for (int i = 0; i < 3; i++) sample_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_rise", 32'(rise_pulse), 32'd0);
    chk("arst_fall", 32'(fall_pulse), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    send_word(8'hA5, 1'b0);
    chk("after_rst_data", 32'(out_data), 32'h0000_00A5);
    chk("after_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick("after_rst_drain");

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 400; n++) begin
      y         = 1'($urandom_range(0, 1));
      sample_en = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
